// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the instruction and data cache refill ports.
// One burst is outstanding at a time; R beats are steered to the owning cache only.
module axi_rd_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [3:0]  ID_INST      = 4'd0,
    parameter logic [3:0]  ID_DATA      = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rd_req_inst,
    input  logic [2:0]  rd_type_inst,
    input  logic [31:0] rd_addr_inst,
    output logic        rd_rdy_inst,
    output logic        ret_valid_inst,
    output logic        ret_last_inst,
    output logic [31:0] ret_data_inst,
    input  logic        rd_req_data,
    input  logic [2:0]  rd_type_data,
    input  logic [31:0] rd_addr_data,
    output logic        rd_rdy_data,
    output logic        ret_valid_data,
    output logic        ret_last_data,
    output logic [31:0] ret_data_data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err
);
    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           owner_data_q, owner_data_d;
    logic [31:0]    addr_q, addr_d;
    logic [7:0]     len_q, len_d;
    logic [2:0]     size_q, size_d;
    logic [3:0]     id_q, id_d;
    logic [7:0]     beat_q, beat_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic           err_q, err_d;

    logic           pick_data_s;
    logic [31:0]    sel_addr_s;
    logic [2:0]     sel_type_s;
    logic           beat_bad_s;

    // Arbitration, request latching, beat accounting and error detection.
    always_comb begin
        state_d      = state_q;
        owner_data_d = owner_data_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        id_d         = id_q;
        beat_d       = beat_q;
        starve_d     = starve_q;
        err_d        = err_q;

        pick_data_s = rd_req_data && !(rd_req_inst && (starve_q == STARVE_MAX));
        sel_addr_s  = pick_data_s ? rd_addr_data : rd_addr_inst;
        sel_type_s  = pick_data_s ? rd_type_data : rd_type_inst;
        beat_bad_s  = (rresp != 2'b00) || (rid != id_q) || (beat_q > len_q)
                      || (rlast && (beat_q != len_q));

        case (state_q)
            S_IDLE: begin
                if (rd_req_inst || rd_req_data) begin
                    state_d      = S_ADDR;
                    owner_data_d = pick_data_s;
                    addr_d       = sel_addr_s;
                    id_d         = pick_data_s ? ID_DATA : ID_INST;
                    if (sel_type_s == 3'b100) begin
                        len_d  = 8'd3;
                        size_d = 3'b010;
                    end else begin
                        len_d  = 8'd0;
                        size_d = {1'b0, sel_type_s[1:0]};
                    end
                    // Only data grants that bypass a waiting inst request count toward starvation.
                    if (pick_data_s && rd_req_inst) begin
                        starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
                    end else begin
                        starve_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    state_d = S_DATA;
                    beat_d  = 8'd0;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                if (rvalid) begin
                    if (beat_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    beat_d = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
                    if (rlast) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; resetn clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            owner_data_q <= 1'b0;
            addr_q       <= 32'd0;
            len_q        <= 8'd0;
            size_q       <= 3'd0;
            id_q         <= 4'd0;
            beat_q       <= 8'd0;
            starve_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            id_q         <= id_d;
            beat_q       <= beat_d;
            starve_q     <= starve_d;
            err_q        <= err_d;
        end
    end

    assign arvalid = (state_q == S_ADDR);
    assign rready  = (state_q == S_DATA);
    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = 2'b01;
    assign rd_err  = err_q;

    // Handshake and return beats go to the owner only, gated by state so reset silences them at once.
    assign rd_rdy_inst    = arvalid && arready && !owner_data_q;
    assign rd_rdy_data    = arvalid && arready && owner_data_q;
    assign ret_valid_inst = rready && rvalid && !owner_data_q;
    assign ret_valid_data = rready && rvalid && owner_data_q;
    assign ret_last_inst  = rready && rvalid && rlast && !owner_data_q;
    assign ret_last_data  = rready && rvalid && rlast && owner_data_q;
    assign ret_data_inst  = (rready && !owner_data_q) ? rdata : 32'd0;
    assign ret_data_data  = (rready && owner_data_q) ? rdata : 32'd0;
endmodule
